// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: L1 instruction-cache miss refill and whole-cache flush sequencer.
// Optional macro ICACHE_INVALID_FIRST_EN: prefer the lowest invalid way as refill victim.
module icache_refill_ctrl #(
   parameter  int unsigned N_WAY  = 4,
   parameter  int unsigned N_SETS = 64,
   parameter  int unsigned TAG_W  = 20,
   parameter  int unsigned LINE_W = 512,
   localparam int unsigned IDX_W  = $clog2(N_SETS)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   output logic                   flush_done_o,
   input  logic                   miss_valid_i,
   output logic                   miss_ready_o,
   input  logic [TAG_W-1:0]       miss_tag_i,
   input  logic [IDX_W-1:0]       miss_idx_i,
   input  logic [N_WAY-1:0]       valid_vec_i,
   output logic                   l2_req_valid_o,
   input  logic                   l2_req_ready_i,
   output logic [TAG_W+IDX_W-1:0] l2_req_addr_o,
   input  logic                   l2_rsp_valid_i,
   output logic                   l2_rsp_ready_o,
   input  logic [LINE_W-1:0]      l2_rsp_line_i,
   output logic                   mem_we_o,
   output logic [N_WAY-1:0]       mem_way_o,
   output logic [IDX_W-1:0]       mem_idx_o,
   output logic [TAG_W-1:0]       mem_tag_o,
   output logic [LINE_W-1:0]      mem_line_o,
   output logic                   mem_valid_o,
   output logic                   refill_done_o,
   output logic                   busy_o
);
   localparam int unsigned      WAY_W    = $clog2(N_WAY);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SETS - 1);

   typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_L2_REQ, S_L2_WAIT, S_WRITE} state_t;

   state_t              r_state, w_state_nxt;
   logic [IDX_W-1:0]    r_cnt, w_cnt_nxt;
   logic [WAY_W-1:0]    r_ptr, w_ptr_nxt;
   logic [WAY_W-1:0]    r_victim, w_victim_nxt, w_victim_sel;
   logic [TAG_W-1:0]    r_tag, w_tag_nxt;
   logic [IDX_W-1:0]    r_idx, w_idx_nxt;
   logic [LINE_W-1:0]   r_line, w_line_nxt;

   logic                   w_flush_done_nxt, w_req_valid_nxt, w_rsp_ready_nxt;
   logic [TAG_W+IDX_W-1:0] w_req_addr_nxt;
   logic                   w_we_nxt, w_mem_valid_nxt, w_refill_done_nxt, w_busy_nxt;
   logic [N_WAY-1:0]       w_way_nxt;
   logic [IDX_W-1:0]       w_mem_idx_nxt;
   logic [TAG_W-1:0]       w_mem_tag_nxt;
   logic [LINE_W-1:0]      w_mem_line_nxt;

`ifdef ICACHE_INVALID_FIRST_EN
   // Lowest-index invalid way wins; round-robin only when the set is full.
   always_comb begin
      w_victim_sel = r_ptr;
      for (int k = int'(N_WAY) - 1; k >= 0; k--) begin
         if (!valid_vec_i[k]) w_victim_sel = WAY_W'(k);
      end
   end
`else
   logic w_unused_valid_vec;
   assign w_unused_valid_vec = ^valid_vec_i;
   assign w_victim_sel       = r_ptr;
`endif

   assign miss_ready_o = (r_state == S_IDLE) && !flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_ptr    <= '0;
         r_victim <= '0;
         r_tag    <= '0;
         r_idx    <= '0;
         r_line   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_ptr    <= w_ptr_nxt;
         r_victim <= w_victim_nxt;
         r_tag    <= w_tag_nxt;
         r_idx    <= w_idx_nxt;
         r_line   <= w_line_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_ptr_nxt    = r_ptr;
      w_victim_nxt = r_victim;
      w_tag_nxt    = r_tag;
      w_idx_nxt    = r_idx;
      w_line_nxt   = r_line;
      case (r_state)
         S_IDLE: begin
            if (flush_i) begin
               w_state_nxt = S_FLUSH;
               w_cnt_nxt   = '0;
            end else if (miss_valid_i) begin
               w_state_nxt  = S_L2_REQ;
               w_tag_nxt    = miss_tag_i;
               w_idx_nxt    = miss_idx_i;
               w_victim_nxt = w_victim_sel;
            end
         end
         S_FLUSH: begin
            w_cnt_nxt = r_cnt + IDX_W'(1);
            if (r_cnt == LAST_IDX) w_state_nxt = S_IDLE;
         end
         S_L2_REQ: begin
            if (l2_req_ready_i) w_state_nxt = S_L2_WAIT;
         end
         S_L2_WAIT: begin
            if (l2_rsp_valid_i) begin
               w_state_nxt = S_WRITE;
               w_line_nxt  = l2_rsp_line_i;
            end
         end
         S_WRITE: begin
            w_ptr_nxt   = r_ptr + WAY_W'(1);
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Outputs are registered: decode them from the state being entered.
      w_flush_done_nxt  = 1'b0;
      w_req_valid_nxt   = 1'b0;
      w_req_addr_nxt    = '0;
      w_rsp_ready_nxt   = 1'b0;
      w_we_nxt          = 1'b0;
      w_way_nxt         = '0;
      w_mem_idx_nxt     = '0;
      w_mem_tag_nxt     = '0;
      w_mem_line_nxt    = '0;
      w_mem_valid_nxt   = 1'b0;
      w_refill_done_nxt = 1'b0;
      w_busy_nxt        = (w_state_nxt != S_IDLE);
      case (w_state_nxt)
         S_FLUSH: begin
            w_we_nxt         = 1'b1;
            w_way_nxt        = '1;
            w_mem_idx_nxt    = w_cnt_nxt;
            w_flush_done_nxt = (w_cnt_nxt == LAST_IDX);
         end
         S_L2_REQ: begin
            w_req_valid_nxt = 1'b1;
            w_req_addr_nxt  = {w_tag_nxt, w_idx_nxt};
         end
         S_L2_WAIT: w_rsp_ready_nxt = 1'b1;
         S_WRITE: begin
            w_we_nxt          = 1'b1;
            w_way_nxt         = N_WAY'(1) << w_victim_nxt;
            w_mem_idx_nxt     = w_idx_nxt;
            w_mem_tag_nxt     = w_tag_nxt;
            w_mem_line_nxt    = w_line_nxt;
            w_mem_valid_nxt   = 1'b1;
            w_refill_done_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         flush_done_o   <= 1'b0;
         l2_req_valid_o <= 1'b0;
         l2_req_addr_o  <= '0;
         l2_rsp_ready_o <= 1'b0;
         mem_we_o       <= 1'b0;
         mem_way_o      <= '0;
         mem_idx_o      <= '0;
         mem_tag_o      <= '0;
         mem_line_o     <= '0;
         mem_valid_o    <= 1'b0;
         refill_done_o  <= 1'b0;
         busy_o         <= 1'b0;
      end else begin
         flush_done_o   <= w_flush_done_nxt;
         l2_req_valid_o <= w_req_valid_nxt;
         l2_req_addr_o  <= w_req_addr_nxt;
         l2_rsp_ready_o <= w_rsp_ready_nxt;
         mem_we_o       <= w_we_nxt;
         mem_way_o      <= w_way_nxt;
         mem_idx_o      <= w_mem_idx_nxt;
         mem_tag_o      <= w_mem_tag_nxt;
         mem_line_o     <= w_mem_line_nxt;
         mem_valid_o    <= w_mem_valid_nxt;
         refill_done_o  <= w_refill_done_nxt;
         busy_o         <= w_busy_nxt;
      end
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: scoreboard bench for the icache refill/flush controller.
module tb_icache_refill_ctrl;
   localparam int unsigned TAG_W = 20;
   localparam int unsigned IDX_W = 6;
   localparam int unsigned LINE_W = 512;
`ifdef ICACHE_INVALID_FIRST_EN
   localparam bit INV_FIRST = 1'b1;
`else
   localparam bit INV_FIRST = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_i, flush_i, flush_done_o;
   logic              miss_valid_i, miss_ready_o;
   logic [TAG_W-1:0]  miss_tag_i;
   logic [IDX_W-1:0]  miss_idx_i;
   logic [3:0]        valid_vec_i;
   logic              l2_req_valid_o, l2_req_ready_i;
   logic [TAG_W+IDX_W-1:0] l2_req_addr_o;
   logic              l2_rsp_valid_i, l2_rsp_ready_o;
   logic [LINE_W-1:0] l2_rsp_line_i;
   logic              mem_we_o, mem_valid_o, refill_done_o, busy_o;
   logic [3:0]        mem_way_o;
   logic [IDX_W-1:0]  mem_idx_o;
   logic [TAG_W-1:0]  mem_tag_o;
   logic [LINE_W-1:0] mem_line_o;

   icache_refill_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_done_o(flush_done_o),
      .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
      .miss_tag_i(miss_tag_i), .miss_idx_i(miss_idx_i), .valid_vec_i(valid_vec_i),
      .l2_req_valid_o(l2_req_valid_o), .l2_req_ready_i(l2_req_ready_i),
      .l2_req_addr_o(l2_req_addr_o), .l2_rsp_valid_i(l2_rsp_valid_i),
      .l2_rsp_ready_o(l2_rsp_ready_o), .l2_rsp_line_i(l2_rsp_line_i),
      .mem_we_o(mem_we_o), .mem_way_o(mem_way_o), .mem_idx_o(mem_idx_o),
      .mem_tag_o(mem_tag_o), .mem_line_o(mem_line_o), .mem_valid_o(mem_valid_o),
      .refill_done_o(refill_done_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic [IDX_W-1:0]  idx;
      logic [3:0]        way;
      logic [LINE_W-1:0] line;
      int                lat;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_pass = 0;
   logic [1:0] m_ptr = 2'd0;

   // Observed results of the last refill run.
   int                ob_lat, ob_nwr;
   logic              ob_acc, ob_addr_ok;
   logic [3:0]        ob_way;
   logic [IDX_W-1:0]  ob_idx;
   logic [TAG_W-1:0]  ob_tag;
   logic [LINE_W-1:0] ob_line;
   logic              ob_valid;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // Reference victim choice; the round-robin pointer advances on every install.
   task automatic push_exp(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                           input logic [3:0] vv, input logic [LINE_W-1:0] line, input int lat);
      exp_t       e;
      logic [1:0] v;
      v = m_ptr;
      for (int k = 3; k >= 0; k--) if (INV_FIRST && !vv[k]) v = 2'(k);
      e.tag = tag; e.idx = idx; e.way = 4'b0001 << v; e.line = line; e.lat = lat;
      exp_q.push_back(e);
      m_ptr = m_ptr + 2'd1;
   endtask

   task automatic apply_reset();
      rst_i = 1'b1; flush_i = 1'b0; miss_valid_i = 1'b0; miss_tag_i = '0; miss_idx_i = '0;
      valid_vec_i = 4'hF; l2_req_ready_i = 1'b0; l2_rsp_valid_i = 1'b0; l2_rsp_line_i = '0;
      step(); step();
      rst_i = 1'b0;
      m_ptr = 2'd0;
   endtask

   // Drives one miss and a simple L2 responder; cycle 0 is the acceptance cycle.
   task automatic run_refill(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                             input logic [3:0] vv, input logic [LINE_W-1:0] line,
                             input int req_dly, input int rsp_dly);
      int   nreq, nwait;
      logic done;
      miss_tag_i = tag; miss_idx_i = idx; valid_vec_i = vv; miss_valid_i = 1'b1;
      #1;
      ob_acc = miss_ready_o;
      step();
      miss_valid_i = 1'b0;
      ob_lat = 1; ob_nwr = 0; ob_addr_ok = 1'b1; nreq = 0; nwait = 0; done = 1'b0;
      ob_way = '0; ob_idx = '0; ob_tag = '0; ob_line = '0; ob_valid = 1'b0;
      while (!done && ob_lat <= 60) begin
         l2_req_ready_i = 1'b0;
         l2_rsp_valid_i = 1'b0;
         l2_rsp_line_i  = ~line;
         if (l2_req_valid_o) begin
            if (l2_req_addr_o !== {tag, idx}) ob_addr_ok = 1'b0;
            l2_req_ready_i = (nreq >= req_dly);
            nreq++;
         end
         if (l2_rsp_ready_o && nwait >= rsp_dly) begin
            l2_rsp_valid_i = 1'b1;
            l2_rsp_line_i  = line;
         end
         if (l2_rsp_ready_o) nwait++;
         if (mem_we_o) begin
            ob_nwr++;
            ob_way = mem_way_o; ob_idx = mem_idx_o; ob_tag = mem_tag_o;
            ob_line = mem_line_o; ob_valid = mem_valid_o;
         end
         if (refill_done_o) done = 1'b1;
         else begin
            step();
            ob_lat++;
         end
      end
      if (!done) ob_lat = -1;
      if (nreq != req_dly + 1) ob_addr_ok = 1'b0;
      l2_req_ready_i = 1'b0; l2_rsp_valid_i = 1'b0;
      step();
      if (mem_we_o) ob_nwr++;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({busy_o, mem_we_o, l2_req_valid_o, l2_rsp_ready_o, refill_done_o, flush_done_o} !== 6'b0)
         $display("FAIL reset_outputs got=%b exp=000000",
                  {busy_o, mem_we_o, l2_req_valid_o, l2_rsp_ready_o, refill_done_o, flush_done_o});
      else n_pass++;
      n_checks++;
      if (miss_ready_o !== 1'b1) $display("FAIL reset_miss_ready got=%b exp=1", miss_ready_o);
      else n_pass++;
   endtask

   task automatic test_reset_mid_refill();
      exp_t e;
      miss_tag_i = 20'h11111; miss_idx_i = 6'd9; miss_valid_i = 1'b1;
      step();
      miss_valid_i = 1'b0; l2_req_ready_i = 1'b1;
      step();
      l2_req_ready_i = 1'b0;
      n_checks++;
      if (l2_rsp_ready_o !== 1'b1) $display("FAIL mid_in_wait got=%b exp=1", l2_rsp_ready_o);
      else n_pass++;
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      m_ptr = 2'd0;
      n_checks++;
      if ({busy_o, mem_we_o, l2_req_valid_o, l2_rsp_ready_o, refill_done_o, miss_ready_o} !== 6'b000001)
         $display("FAIL mid_reset_state got=%b exp=000001",
                  {busy_o, mem_we_o, l2_req_valid_o, l2_rsp_ready_o, refill_done_o, miss_ready_o});
      else n_pass++;
      push_exp(20'h12345, 6'd5, 4'hF, rand_line(), 3);
      e = exp_q.pop_front();
      run_refill(e.tag, e.idx, 4'hF, e.line, 0, 0);
      n_checks++;
      if (ob_addr_ok !== 1'b1 || ob_acc !== 1'b1)
         $display("FAIL mid_l2_addr got_ok=%b acc=%b exp=1", ob_addr_ok, ob_acc);
      else n_pass++;
      n_checks++;
      if (ob_way !== e.way || ob_tag !== e.tag || ob_idx !== e.idx)
         $display("FAIL mid_write got=%b/%h/%0d exp=%b/%h/%0d", ob_way, ob_tag, ob_idx, e.way, e.tag, e.idx);
      else n_pass++;
   endtask

   task automatic test_basic_refill();
      exp_t e;
      apply_reset();
      push_exp(20'hABCDE, 6'd3, 4'h0, rand_line(), 3);
      e = exp_q.pop_front();
      run_refill(e.tag, e.idx, 4'h0, e.line, 0, 0);
      n_checks++;
      if (ob_lat !== e.lat) $display("FAIL basic_latency got=%0d exp=%0d", ob_lat, e.lat);
      else n_pass++;
      n_checks++;
      if (ob_way !== e.way) $display("FAIL basic_way got=%b exp=%b", ob_way, e.way);
      else n_pass++;
      n_checks++;
      if (ob_idx !== e.idx || ob_tag !== e.tag)
         $display("FAIL basic_idx_tag got=%0d/%h exp=%0d/%h", ob_idx, ob_tag, e.idx, e.tag);
      else n_pass++;
      n_checks++;
      if (ob_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", ob_valid);
      else n_pass++;
      n_checks++;
      if (ob_line !== e.line) $display("FAIL basic_line got=%h exp=%h", ob_line, e.line);
      else n_pass++;
      n_checks++;
      if (ob_nwr !== 1 || busy_o !== 1'b0)
         $display("FAIL basic_single_write got=%0d busy=%b exp=1 busy=0", ob_nwr, busy_o);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      exp_t e;
      push_exp(20'h0F0F0, 6'd44, 4'b0110, rand_line(), 13);
      e = exp_q.pop_front();
      run_refill(e.tag, e.idx, 4'b0110, e.line, 4, 6);
      n_checks++;
      if (ob_lat !== e.lat) $display("FAIL bp_latency got=%0d exp=%0d", ob_lat, e.lat);
      else n_pass++;
      n_checks++;
      if (ob_addr_ok !== 1'b1) $display("FAIL bp_req_hold got=%b exp=1", ob_addr_ok);
      else n_pass++;
      n_checks++;
      if (ob_nwr !== 1) $display("FAIL bp_write_count got=%0d exp=1", ob_nwr);
      else n_pass++;
      n_checks++;
      if (ob_way !== e.way || ob_line !== e.line)
         $display("FAIL bp_payload got_way=%b exp_way=%b line_ok=%b", ob_way, e.way, ob_line === e.line);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      exp_t e;
      logic [LINE_W-1:0] l;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         l = rand_line();
         push_exp(TAG_W'(32'h100 + i), 6'd7, 4'hF, l, 3);
      end
      for (int i = 0; i < 5; i++) begin
         e = exp_q.pop_front();
         run_refill(e.tag, e.idx, 4'hF, e.line, 0, 0);
         n_checks++;
         if (ob_way !== e.way || ob_lat !== e.lat)
            $display("FAIL rr_way_%0d got=%b lat=%0d exp=%b lat=%0d", i, ob_way, ob_lat, e.way, e.lat);
         else n_pass++;
      end
   endtask

   task automatic test_flush_collision();
      exp_t e;
      logic [IDX_W-1:0] ei;
      push_exp(20'h5A5A5, 6'd60, 4'hF, rand_line(), 3);
      e = exp_q.pop_front();
      flush_i = 1'b1; miss_valid_i = 1'b1; miss_tag_i = e.tag; miss_idx_i = e.idx;
      #1;
      n_checks++;
      if (miss_ready_o !== 1'b0) $display("FAIL flush_prio_ready got=%b exp=0", miss_ready_o);
      else n_pass++;
      step();
      flush_i = 1'b0;
      for (int i = 0; i < 64; i++) begin
         ei = IDX_W'(i);
         n_checks++;
         if ({mem_we_o, mem_way_o, mem_idx_o, mem_valid_o, mem_tag_o == '0, mem_line_o == '0,
              flush_done_o, miss_ready_o, busy_o} !==
             {1'b1, 4'b1111, ei, 1'b0, 1'b1, 1'b1, (i == 63), 1'b0, 1'b1})
            $display("FAIL flush_cycle_%0d got we=%b way=%b idx=%0d v=%b done=%b rdy=%b exp idx=%0d done=%b",
                     i, mem_we_o, mem_way_o, mem_idx_o, mem_valid_o, flush_done_o, miss_ready_o, i, i == 63);
         else n_pass++;
         step();
      end
      n_checks++;
      if ({miss_ready_o, mem_we_o, busy_o} !== 3'b100)
         $display("FAIL flush_end_ready got=%b exp=100", {miss_ready_o, mem_we_o, busy_o});
      else n_pass++;
      run_refill(e.tag, e.idx, 4'hF, e.line, 0, 0);
      n_checks++;
      if (ob_acc !== 1'b1 || ob_way !== e.way || ob_lat !== e.lat)
         $display("FAIL flush_then_miss got acc=%b way=%b lat=%0d exp acc=1 way=%b lat=%0d",
                  ob_acc, ob_way, ob_lat, e.way, e.lat);
      else n_pass++;
   endtask

   task automatic test_invalid_first();
      exp_t e;
      apply_reset();
      push_exp(20'h00ABC, 6'd12, 4'b1011, rand_line(), 3);
      push_exp(20'h00ABD, 6'd13, 4'b1111, rand_line(), 3);
      e = exp_q.pop_front();
      run_refill(e.tag, e.idx, 4'b1011, e.line, 0, 0);
      n_checks++;
      if (ob_way !== e.way) $display("FAIL invfirst_partial got=%b exp=%b", ob_way, e.way);
      else n_pass++;
      e = exp_q.pop_front();
      run_refill(e.tag, e.idx, 4'b1111, e.line, 0, 0);
      n_checks++;
      if (ob_way !== e.way) $display("FAIL invfirst_full got=%b exp=%b", ob_way, e.way);
      else n_pass++;
   endtask

   initial begin
      apply_reset();
      test_reset();
      test_reset_mid_refill();
      test_basic_refill();
      test_backpressure();
      test_round_robin();
      test_flush_collision();
      test_invalid_first();
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Sequencing controller for the L1 instruction-cache arrays.
- On a lookup miss it fetches the line from L2, selects a victim way and writes line, tag and valid bit into the selected way. The comparison block then hits on the replayed lookup.
- It also performs the whole-cache invalidate (flush) sweep.
- Sits between the icache lookup/comparison path, the L2 request port and the tag/data/valid array write port.

Parameters:
- N_WAY, 4, associativity; power of two, ≥2.
- N_SETS, 64, number of sets; power of two.
- TAG_W, 20, tag width in bits.
- LINE_W, 512, cache line width in bits.
- IDX_W, $clog2(N_SETS), set index width (localparam).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  request invalidate of all sets; level, sampled in IDLE.
- flush_done_o  out  1  one-cycle pulse on the last sweep write.
- miss_valid_i  in  1  lookup missed; tag/idx are stable while high.
- miss_ready_o  out  1  miss accepted; high only in IDLE with flush_i low.
- miss_tag_i  in  TAG_W  tag of the missing line.
- miss_idx_i  in  IDX_W  set index of the missing line.
- valid_vec_i  in  N_WAY  valid bits of set miss_idx_i (used only with the optional feature).
- l2_req_valid_o  out  1  line read request to L2.
- l2_req_ready_i  in  1  L2 accepts the request.
- l2_req_addr_o  out  TAG_W+IDX_W  {tag, idx} line address.
- l2_rsp_valid_i  in  1  L2 returns the line.
- l2_rsp_ready_o  out  1  controller accepts the response.
- l2_rsp_line_i  in  LINE_W  returned line data.
- mem_we_o  out  1  array write strobe.
- mem_way_o  out  N_WAY  one-hot way mask for the write (all ones during flush).
- mem_idx_o  out  IDX_W  set written.
- mem_tag_o  out  TAG_W  tag written.
- mem_line_o  out  LINE_W  data written.
- mem_valid_o  out  1  valid bit written (1 on refill, 0 on flush).
- refill_done_o  out  1  one-cycle pulse; line installed, lookup may replay next cycle.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, FLUSH, L2_REQ, L2_WAIT, WRITE.
- Reset (rst_i=1 at an edge, from any state): state=IDLE, flush counter=0, victim pointer=0, latched tag/idx/line=0. All outputs 0 except miss_ready_o, which follows IDLE rules from the next cycle. An in-flight L2 transaction is abandoned; the L2 side must also be reset.
- IDLE:
  - flush_i=1 → FLUSH, counter=0. Flush has priority over a simultaneous miss; miss_ready_o=0 that cycle.
  - Otherwise miss_valid_i & miss_ready_o → latch tag, idx and victim way → L2_REQ.
- FLUSH:
  - Each cycle: mem_we_o=1, mem_way_o=all ones, mem_idx_o=counter, mem_valid_o=0, mem_tag_o=0, mem_line_o=0.
  - Counter increments each cycle.
  - At counter==N_SETS-1: flush_done_o=1 → IDLE.
  - Sweep takes exactly N_SETS cycles.
  - flush_i is ignored while in FLUSH. If flush_i is still high on return to IDLE, a new sweep starts.
- L2_REQ: l2_req_valid_o=1, l2_req_addr_o={tag,idx} (registered). On l2_req_ready_i → L2_WAIT. Valid is held until ready is seen.
- L2_WAIT: l2_rsp_ready_o=1. On l2_rsp_valid_i, latch the line → WRITE.
- WRITE (exactly 1 cycle):
  - Outputs: mem_we_o=1, mem_way_o=onehot(victim), mem_idx_o=idx, mem_tag_o=tag, mem_line_o=line, mem_valid_o=1, refill_done_o=1.
  - Victim pointer advances by 1 modulo N_WAY (natural wrap N_WAY-1→0).
  - Next state IDLE.
- Minimum miss-to-refill_done latency: 3 cycles after acceptance, i.e. L2_REQ with ready, L2_WAIT with rsp valid, then WRITE.
- Victim pointer is global across sets and advances only on WRITE; flush does not change it.
- Outputs not driven by the current state are 0; mem_* payloads are 0 whenever mem_we_o=0.

Optional Feature:
- Macro ICACHE_INVALID_FIRST_EN.
- Defined: at miss acceptance, if valid_vec_i != all ones, the victim is the lowest-index way with valid_vec_i[k]=0. The round-robin pointer is used only when all ways are valid. The pointer still advances on every WRITE.
- Undefined: valid_vec_i is ignored and the victim is always the round-robin pointer.

Test Plan:
- Reset mid-refill: rst_i in L2_WAIT → next cycle busy_o=0, all strobes 0, miss_ready_o=1. Then a miss with tag=0x12345, idx=5 is issued with no pending response → l2_req_addr_o={0x12345,5}.
- Basic refill, zero-wait L2: miss tag=0xABCDE, idx=3 → refill_done_o exactly 3 cycles after acceptance. In that cycle: mem_way_o=0001, mem_idx_o=3, mem_tag_o=0xABCDE, mem_valid_o=1, mem_line_o equals the returned line.
- L2 backpressure: l2_req_ready_i low for 4 cycles, then response delayed 6 cycles → l2_req_valid_o held with a constant address. Exactly one WRITE occurs; refill_done_o arrives at cycle 13 after acceptance.
- Round-robin wrap: five consecutive refills to idx=7 → mem_way_o sequence 0001, 0010, 0100, 1000, 0001.
- Flush vs miss collision: flush_i=1 and miss_valid_i=1 in the same IDLE cycle → miss_ready_o=0. Then 64 write cycles with idx 0..63, mem_way_o=1111, mem_valid_o=0, and flush_done_o on idx 63. The miss is accepted on the following cycle.
- ICACHE_INVALID_FIRST_EN defined, valid_vec_i=1011, pointer=0 → victim mem_way_o=0100 and the pointer becomes 1. With valid_vec_i=1111 the victim is 0010.
